fir_tap_scheduler: RTL and testbench
====================================

Name: fir_tap_scheduler

Overview:
Time-multiplexed stereo FIR sequencer that shares one 24x16 multiply-accumulate across both channels and all taps. It owns the per-channel circular sample history and the filter selection from board switches. It generates coefficient ROM addresses and produces saturated stereo results once per audio packet. It sits between the I2S/packet receive logic (new_packet, input samples) and the DAC transmit path.

Parameters:
NUM_TAPS, 89, taps per filter; also the history depth per channel
DATA_W, 24, signed sample width
COEF_W, 16, signed Q1.15 coefficient width
TAP_W, 7, tap index width, equal to ceil(log2(NUM_TAPS))
FILT_W, 3, filter index width
ACC_W, DATA_W+COEF_W+TAP_W (47), accumulator width

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
sw  in  4  filter select switches
new_packet  in  1  a new stereo sample pair is valid on in_left/in_right
in_left  in  DATA_W  signed left sample
in_right  in  DATA_W  signed right sample
coef_addr  out  FILT_W+TAP_W  coefficient ROM address, {filter, tap}
coef_data  in  COEF_W  signed ROM output, 1-cycle registered latency
out_left  out  DATA_W  signed filtered left sample, registered
out_right  out  DATA_W  signed filtered right sample, registered
out_valid  out  1  1-cycle pulse when out_left/out_right update
busy  out  1  high in every state except IDLE
selected_filter  out  FILT_W  filter latched for the current or last sample
overrun  out  1  1-cycle pulse when new_packet is dropped

Behaviour:
- Reset (synchronous): state IDLE. All history registers cleared to 0. Write pointer = 0. Outputs out_left, out_right, out_valid, busy, selected_filter, overrun, coef_addr all 0. Accumulator = 0. Reset wins over every other event, including reset mid-MAC: the sample in flight is abandoned and no out_valid is issued.
- Filter map: sw==0 -> 0 (bypass); otherwise index = (position of highest set bit) + 1. So 0001->1, 0010->2, 0100->3, 1000->4, 1011->4.
- sw is sampled only in LOAD. Changes at any other time have no effect until the next sample.
- States: IDLE, LOAD, MAC_L, MAC_R, OUT.
- IDLE: if new_packet=1 at cycle A, go to LOAD. new_packet held high re-triggers on every return to IDLE.
- LOAD (A+1): write in_left/in_right (captured at A) into history[wp]. Latch selected_filter. Clear accumulator. If filter 0, go to OUT; else go to MAC_L.
- MAC_L (A+2..A+91): on A+2+k for k=0..88, coef_addr={filt,k}. On A+3+k, acc += coef_data * hist_L[(wp-k) mod NUM_TAPS]. Wrap is explicit: wp-k<0 adds NUM_TAPS. Tap 0 is the newest sample. Then go to MAC_R with acc cleared, after capturing the left result.
- MAC_R (A+92..A+181): identical schedule on right history.
- OUT (A+182):
  - out_valid=1 for one cycle, out_* updated.
  - wp advances: wraps 88->0.
  - Return to IDLE. Back-to-back packets are accepted every 183 cycles minimum.
- Bypass: out_* = the input samples. LOAD goes directly to OUT at A+2; history is still written.
- Result = acc >>> (COEF_W-1), arithmetic shift (truncate toward -inf). Saturate to [0x800000, 0x7FFFFF]. The full-precision product is 40 bits; the accumulator is never truncated before the final shift.
- overrun: new_packet=1 in any state other than IDLE pulses overrun the next cycle. The packet is dropped; state and outputs are unaffected.
- coef_addr holds its last value outside MAC states.

Decomposition:
- Shared package fir_pkg:
  - DATA_W, COEF_W, NUM_TAPS, TAP_W, FILT_W
  - state enum
  - typedefs sample_t, coef_t, acc_t
  - function sat_shift(acc_t) -> sample_t
- One sub-module, fir_mac_unit: registered signed multiply, accumulate, clear input, saturating output. Shared by both channel phases.

Test Plan:
- Impulse: sw=0001, ROM filter1 all taps=16384. Drive in_left=0x100000, in_right=0x000000, then 99 zero packets. Expect out_left=0x080000 for packets 0..88 and 0 from packet 89. out_right=0 throughout. out_valid exactly 182 cycles after each accepted new_packet.
- Saturation: all coef=32767, 89 packets of L=0x7FFFFF, R=0x800000. Expect final out_left=0x7FFFFF and out_right=0x800000.
- Overrun: pulse new_packet at A and A+50. Expect overrun=1 at A+51, a single out_valid at A+182, and history advanced once.
- Reset mid-op: rst at A+100. Expect IDLE, busy=0, out_valid never asserted, and a subsequent impulse response identical to the first test (history cleared).
- Filter switch: change sw 0001->0100 at A+60. Expect coef_addr[9:7]=1 for that sample. The next sample shows selected_filter=3 and coef_addr[9:7]=3.
- Bypass: sw=0000, L=0x123456, R=0xFEDCBA. Expect out_valid at A+2 with identical values, busy low at A+3, and no MAC addresses issued.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, state encoding and helpers for the stereo FIR sequencer
package fir_pkg;
    localparam int NUM_TAPS = 89;
    localparam int DATA_W = 24;
    localparam int COEF_W = 16;
    localparam int TAP_W = 7;
    localparam int FILT_W = 3;
    localparam int ACC_W = DATA_W + COEF_W + TAP_W;
    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [2:0] {IDLE, LOAD, MAC_L, MAC_R, OUT} state_t;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // Drop the Q1.15 fraction (toward -inf), then clamp to the sample range
    function automatic sample_t sat_shift(acc_t a);
        acc_t s;
        s = a >>> (COEF_W - 1);
        return (&s[ACC_W-1:DATA_W-1] || ~|s[ACC_W-1:DATA_W-1]) ? s[DATA_W-1:0]
             : {s[ACC_W-1], {(DATA_W-1){~s[ACC_W-1]}}};
    endfunction

    function automatic logic [FILT_W-1:0] filter_map(logic [3:0] sw);
        return sw[3] ? 3'd4 : sw[2] ? 3'd3 : sw[1] ? 3'd2 : {2'b00, sw[0]};
    endfunction
endpackage

// File: rtl/fir_tap_scheduler_mac.sv
// fir_mac_unit: signed 24x16 multiply feeding a full-precision accumulator with saturating readout
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] result
);
    prod_t prod;
    acc_t acc;
    acc_t sum;

    always_comb begin
        prod = prod_t'(coef) * prod_t'(sample);
        sum = acc + acc_t'(prod);
        result = sat_shift(sum);
    end

    // result already includes the current product, so the caller can capture and clear in one cycle
    always_ff @(posedge clk) begin
        acc <= (rst || clear) ? '0 : en ? sum : acc;
    end
endmodule

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: time-multiplexed stereo FIR sequencer sharing one MAC across channels and taps
module fir_tap_scheduler
    import fir_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    sw,
    input  logic                          new_packet,
    input  logic signed [DATA_W-1:0]      in_left,
    input  logic signed [DATA_W-1:0]      in_right,
    output logic [FILT_W+TAP_W-1:0]       coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic signed [DATA_W-1:0]      out_left,
    output logic signed [DATA_W-1:0]      out_right,
    output logic                          out_valid,
    output logic                          busy,
    output logic [FILT_W-1:0]             selected_filter,
    output logic                          overrun
);
    localparam logic [TAP_W-1:0] LAST = TAP_W'(NUM_TAPS);

    state_t state, state_nxt;
    logic [TAP_W-1:0] cnt, wp, tap, idx;
    logic [FILT_W-1:0] filt, f_new;
    sample_t cap_l, cap_r, left_res, mac_sample, mac_result;
    sample_t hist_l [NUM_TAPS];
    sample_t hist_r [NUM_TAPS];
    logic mac, mac_en, mac_clear;

    // cnt runs 0..89 per channel; ROM data for tap cnt-1 arrives while cnt is presented
    always_comb begin
        f_new = filter_map(sw);
        mac = state == MAC_L || state == MAC_R;
        mac_en = mac && cnt != '0;
        mac_clear = state == LOAD || (state == MAC_L && cnt == LAST);
        tap = (cnt == '0) ? '0 : cnt - TAP_W'(1);
        idx = (wp >= tap) ? wp - tap : wp + TAP_W'(NUM_TAPS) - tap;
        mac_sample = (state == MAC_R) ? hist_r[idx] : hist_l[idx];
        busy = state != IDLE;
        selected_filter = filt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = new_packet ? LOAD : IDLE;
            LOAD:    state_nxt = (f_new == '0) ? OUT : MAC_L;
            MAC_L:   state_nxt = (cnt == LAST) ? MAC_R : MAC_L;
            MAC_R:   state_nxt = (cnt == LAST) ? OUT : MAC_R;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist_l[i] <= '0;
                hist_r[i] <= '0;
            end
            wp <= '0;
            cnt <= '0;
            filt <= '0;
            cap_l <= '0;
            cap_r <= '0;
            left_res <= '0;
            out_left <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
            coef_addr <= '0;
        end else begin
            out_valid <= 1'b0;
            overrun <= new_packet && state != IDLE;
            cnt <= (mac && cnt != LAST) ? cnt + TAP_W'(1) : '0;
            if (state == IDLE && new_packet) begin
                cap_l <= in_left;
                cap_r <= in_right;
            end
            if (state == LOAD) begin
                hist_l[wp] <= cap_l;
                hist_r[wp] <= cap_r;
                filt <= f_new;
                if (f_new == '0) begin
                    out_left <= cap_l;
                    out_right <= cap_r;
                    out_valid <= 1'b1;
                end else begin
                    coef_addr <= {f_new, {TAP_W{1'b0}}};
                end
            end
            if (mac && cnt < LAST - TAP_W'(1))
                coef_addr <= {filt, cnt + TAP_W'(1)};
            if (state == MAC_L && cnt == LAST) begin
                left_res <= mac_result;
                coef_addr <= {filt, {TAP_W{1'b0}}};
            end
            if (state == MAC_R && cnt == LAST) begin
                out_left <= left_res;
                out_right <= mac_result;
                out_valid <= 1'b1;
            end
            if (state == OUT)
                wp <= (wp == LAST - TAP_W'(1)) ? '0 : wp + TAP_W'(1);
        end
    end

    fir_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .en     (mac_en),
        .coef   (coef_data),
        .sample (mac_sample),
        .result (mac_result)
    );
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb_fir_tap_scheduler: directed packets with a queued scoreboard checked by an out_valid monitor
module tb_fir_tap_scheduler;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_packet = 1'b0;
    logic [3:0] sw = 4'd0;
    logic [DATA_W-1:0] in_left = '0, in_right = '0, out_left, out_right;
    logic [FILT_W+TAP_W-1:0] coef_addr, ca;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic out_valid, busy, overrun;
    logic [FILT_W-1:0] selected_filter;
    int cyc = 0, total = 0, bad = 0, nvalid = 0, coef_mode = 0, v0 = 0;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int due;
    } exp_t;
    exp_t q[$];
    exp_t e;

    fir_tap_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .sw              (sw),
        .new_packet      (new_packet),
        .in_left         (in_left),
        .in_right        (in_right),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .out_left        (out_left),
        .out_right       (out_right),
        .out_valid       (out_valid),
        .busy            (busy),
        .selected_filter (selected_filter),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: filter1 = 0.5, filter3 = 0.25, others 0; mode 1: every coefficient 32767
    function automatic logic signed [COEF_W-1:0] rom(logic [FILT_W+TAP_W-1:0] a);
        if (coef_mode == 1) return 16'sd32767;
        return (a[9:7] == 3'd1) ? 16'sd16384 : (a[9:7] == 3'd3) ? 16'sd8192 : 16'sd0;
    endfunction

    always @(posedge clk) coef_data <= rom(coef_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            nvalid++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("out_left", out_left, e.l);
                chk("out_right", out_right, e.r);
                chk("valid_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                         input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er,
                         input int lat, input bit push);
        @(negedge clk);
        in_left = l;
        in_right = r;
        new_packet = 1'b1;
        if (push) q.push_back('{el, er, cyc + lat});
        @(negedge clk);
        new_packet = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_left", out_left, 0);
        chk("rst_out_right", out_right, 0);
        chk("rst_filter", selected_filter, 0);
        chk("rst_coef_addr", coef_addr, 0);
        chk("rst_overrun", overrun, 0);

        sw = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            issue(i == 0 ? 24'h100000 : 24'h0, 24'h0, i < 89 ? 24'h080000 : 24'h0, 24'h0, 182, 1'b1);
            wait_idle();
        end

        coef_mode = 1;
        for (int i = 0; i < 89; i++) begin
            issue(24'h7FFFFF, 24'h800000, i == 0 ? 24'h7FFEFF : 24'h7FFFFF,
                  i == 0 ? 24'h800100 : 24'h800000, 182, 1'b1);
            wait_idle();
        end

        coef_mode = 0;
        issue(24'h100000, 24'h0, 24'h0, 24'h0, 182, 1'b0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_filter", selected_filter, 0);
        chk("midrst_coef_addr", coef_addr, 0);
        v0 = nvalid;
        repeat (200) @(negedge clk);
        chk("midrst_no_valid", nvalid, v0);
        for (int i = 0; i < 3; i++) begin
            issue(i == 0 ? 24'h100000 : 24'h0, 24'h0, 24'h080000, 24'h0, 182, 1'b1);
            wait_idle();
        end

        issue(24'h0, 24'h0, 24'h080000, 24'h0, 182, 1'b1);
        repeat (49) @(negedge clk);
        in_left = 24'h100000;
        new_packet = 1'b1;
        @(negedge clk);
        new_packet = 1'b0;
        in_left = 24'h0;
        chk("overrun_pulse", overrun, 1);
        @(negedge clk);
        chk("overrun_clear", overrun, 0);
        v0 = nvalid;
        wait_idle();
        chk("overrun_single_valid", nvalid - v0, 1);

        issue(24'h0, 24'h0, 24'h080000, 24'h0, 182, 1'b1);
        repeat (59) @(negedge clk);
        sw = 4'b0100;
        @(negedge clk);
        chk("switch_addr_hold", coef_addr[9:7], 1);
        chk("switch_filter_hold", selected_filter, 1);
        wait_idle();
        issue(24'h0, 24'h0, 24'h040000, 24'h0, 182, 1'b1);
        @(negedge clk);
        chk("switch_filter_new", selected_filter, 3);
        chk("switch_addr_new", coef_addr, {3'd3, 7'd0});
        wait_idle();

        sw = 4'b0000;
        ca = coef_addr;
        issue(24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 2, 1'b1);
        @(negedge clk);
        chk("bypass_busy_out", busy, 1);
        @(negedge clk);
        chk("bypass_busy_low", busy, 0);
        chk("bypass_no_addr", coef_addr, ca);
        chk("bypass_filter", selected_filter, 0);

        repeat (2) @(negedge clk);
        chk("pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
